// File: rtl/pwm_pcm_pkg.sv
// pwm_pcm_pkg: shared definitions for the PWM-to-PCM receiver.
//   PERIOD_BITS_DEFAULT / PCM_W_DEFAULT : default frame exponent and sample width
//   MIDSCALE                            : count for a 50% duty frame at the default period
//   state_t                             : receiver FSM states
//   sat_to_pcm()                        : frame count -> signed PCM with top-end saturation
package pwm_pcm_pkg;

  localparam int unsigned PERIOD_BITS_DEFAULT = 12;
  localparam int unsigned PCM_W_DEFAULT       = 16;
  localparam int unsigned MIDSCALE            = 1 << (PERIOD_BITS_DEFAULT - 1);

  typedef enum logic [0:0] {
    StSyncWait = 1'b0,  // waiting for the first rising edge or the no-edge timeout
    StMeasure  = 1'b1   // frame-aligned counting, permanent until reset
  } state_t;

  // count is a high-cycle total in 0 .. 2**period_bits. The result occupies the low pcm_w
  // bits. A full-high frame would map to +2**(pcm_w-1), one past the signed maximum, so it is
  // clamped instead of wrapping negative.
  function automatic logic [31:0] sat_to_pcm(input logic [31:0] count,
                                             input int unsigned period_bits,
                                             input int unsigned pcm_w);
    logic signed [31:0] diff;
    logic [31:0]        res;
    if (count >= (32'(1) << period_bits)) begin
      res = (32'(1) << (pcm_w - 1)) - 32'(1);
    end else begin
      diff = $signed(count) - $signed(32'(1) << (period_bits - 1));
      res  = 32'(diff <<< (pcm_w - period_bits));
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchronizer for a single asynchronous bit.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears every stage to 0
//   d_i  : asynchronous input
//   q_o  : synchronized output, Stages cycles of latency
module bit_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pwm_to_pcm.sv
// pwm_to_pcm: recovers signed PCM samples from a 1-bit PWM stream by counting high cycles
// over frames of 2**PERIOD_BITS clocks, and presents one sample per frame on valid/ready.
//   clk       : sample clock, same rate as the PWM source counter
//   rst       : asynchronous active-high reset
//   pwm_in    : asynchronous PWM input
//   pcm_out   : signed recovered sample, stable while pcm_valid=1
//   pcm_valid : sample available, held until accepted
//   pcm_ready : consumer accepts when pcm_valid & pcm_ready at posedge
//   overrun   : sticky, a completed frame was dropped because of backpressure
//   locked    : frame measurement has started
// Build option: define PWM_TO_PCM_AVG_EN to output the mean of the last 4 frame counts.
module pwm_to_pcm
  import pwm_pcm_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = PERIOD_BITS_DEFAULT,
  parameter int unsigned PCM_W       = PCM_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [PCM_W-1:0] pcm_out,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  output logic             locked
);

  localparam int unsigned CntW   = PERIOD_BITS + 1;
  localparam int unsigned MidVal = 1 << (PERIOD_BITS - 1);

  logic                   pwm_s;
  logic                   pwm_d1_q;
  logic                   rise;
  state_t                 state_q, state_d;
  logic [PERIOD_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic [PERIOD_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [CntW-1:0]        high_cnt_q, high_cnt_d;
  logic [CntW-1:0]        frame_count;
  logic [CntW-1:0]        conv_count;
  logic                   frame_done;
  logic [PCM_W-1:0]       pcm_conv;
  logic [PCM_W-1:0]       pcm_q, pcm_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  bit_sync #(
    .Stages(SYNC_STAGES)
  ) u_pwm_sync (
    .clk(clk),
    .rst(rst),
    .d_i(pwm_in),
    .q_o(pwm_s)
  );

  assign rise = pwm_s & ~pwm_d1_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    frame_cnt_d = frame_cnt_q;
    high_cnt_d  = high_cnt_q;
    frame_done  = 1'b0;
    // The current cycle's level is included so the last frame cycle is not lost.
    frame_count = high_cnt_q + CntW'(pwm_s);
    unique case (state_q)
      StSyncWait: begin
        wait_cnt_d = wait_cnt_q + PERIOD_BITS'(1);
        // All-ones means 2**PERIOD_BITS cycles have passed without an edge.
        if (rise || (&wait_cnt_q)) begin
          state_d     = StMeasure;
          wait_cnt_d  = '0;
          frame_cnt_d = '0;
          high_cnt_d  = '0;
        end
      end
      StMeasure: begin
        frame_cnt_d = frame_cnt_q + PERIOD_BITS'(1);
        if (&frame_cnt_q) begin
          frame_done = 1'b1;
          high_cnt_d = '0;
        end else begin
          high_cnt_d = frame_count;
        end
      end
      default: state_d = StSyncWait;
    endcase
  end

`ifdef PWM_TO_PCM_AVG_EN
  localparam int unsigned SumW = CntW + 2;

  logic [CntW-1:0] hist_q [4];
  logic [SumW-1:0] sum_q, sum_d;

  // Running sum: drop the oldest count, add the newest, so the mean is available in the
  // same cycle the frame completes.
  always_comb begin
    sum_d      = sum_q - SumW'(hist_q[3]) + SumW'(frame_count);
    conv_count = sum_d[SumW-1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= CntW'(MidVal);
      end
      sum_q <= SumW'(4 * MidVal);
    end else if (frame_done) begin
      hist_q[0] <= frame_count;
      for (int i = 1; i < 4; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      sum_q <= sum_d;
    end
  end
`else
  assign conv_count = frame_count;
`endif

  assign pcm_conv = PCM_W'(sat_to_pcm(32'(conv_count), PERIOD_BITS, PCM_W));

  always_comb begin
    pcm_d     = pcm_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (frame_done) begin
      // A same-cycle acceptance frees the holding register for the new sample.
      if (!valid_q || pcm_ready) begin
        pcm_d   = pcm_conv;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && pcm_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_d1_q    <= 1'b0;
      state_q     <= StSyncWait;
      wait_cnt_q  <= '0;
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
      pcm_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pwm_d1_q    <= pwm_s;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      high_cnt_q  <= high_cnt_d;
      pcm_q       <= pcm_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign overrun   = overrun_q;
  assign locked    = (state_q == StMeasure);

endmodule
